// File: rtl/ahb_sram_responder.sv
// ahb_sram_responder: AHB slave word-organised SRAM with programmable wait states
// and a two-cycle ERROR response for illegal accesses.
module ahb_sram_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h3800_0000,
  parameter int          ADDR_WIDTH  = 12,
  parameter int          WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  // state   | meaning
  // ST_IDLE | ready, OKAY; completing cycle of an OKAY data phase when dp_done is set
  // ST_WAIT | OKAY data phase, HREADYOUT low while cnt counts down
  // ST_ERR1 | first ERROR cycle, HREADYOUT low
  // ST_ERR2 | second ERROR cycle, HREADYOUT high, next address may be accepted
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  localparam logic [32:0] WIN_BYTES = 33'd4 << ADDR_WIDTH;
  localparam logic [2:0]  WS        = 3'(WAIT_STATES);

  state_t                  state, state_nxt;
  logic [2:0]              cnt, cnt_nxt;
  logic                    dp_done, dp_done_nxt;
  logic                    dp_write;
  logic [2:0]              dp_size;
  logic [1:0]              dp_lane;
  logic [ADDR_WIDTH-1:0]   dp_idx;
  logic [31:0]             mem [2**ADDR_WIDTH];

  logic [31:0]             offset;
  logic [ADDR_WIDTH-1:0]   a_idx;
  logic                    in_range, aligned, legal, accept, hready_int;
  logic                    wr_commit;
  logic [3:0]              be;
  logic [31:0]             wr_word, fwd_word;
  logic                    unused_bits;

  assign offset      = HADDR - BASE_ADDR;
  assign a_idx       = offset[ADDR_WIDTH+1:2];
  assign in_range    = (HADDR >= BASE_ADDR) && ({1'b0, offset} < WIN_BYTES);
  assign unused_bits = ^{HBURST, HTRANS[0], offset[31:ADDR_WIDTH+2], offset[1:0]};

  always_comb begin
    aligned = 1'b0;
    case (HSIZE)
      3'd0:    aligned = 1'b1;
      3'd1:    aligned = !HADDR[0];
      3'd2:    aligned = (HADDR[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign legal      = aligned && in_range;
  assign hready_int = !((state == ST_WAIT) || (state == ST_ERR1));
  assign accept     = HSEL && HREADY && HTRANS[1] && hready_int;
  assign HREADYOUT  = hready_int;
  assign HRESP      = ((state == ST_ERR1) || (state == ST_ERR2)) ? 2'b01 : 2'b00;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    dp_done_nxt = 1'b0;
    case (state)
      ST_IDLE, ST_ERR2: begin
        state_nxt = ST_IDLE;
        if (accept) begin
          if (!legal) begin
            state_nxt = ST_ERR1;
          end else if (WS != 3'd0) begin
            state_nxt = ST_WAIT;
            cnt_nxt   = WS;
          end else begin
            dp_done_nxt = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 3'd1) begin
          state_nxt   = ST_IDLE;
          dp_done_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // only legal OKAY phases ever set dp_done, so errors and reset never write
  assign wr_commit = dp_done && dp_write;

  always_comb begin
    be = 4'b0000;
    case (dp_size)
      3'd0:    be = 4'b0001 << dp_lane;
      3'd1:    be = dp_lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    wr_word = mem[dp_idx];
    for (int i = 0; i < 4; i++) begin
      if (be[i]) wr_word[8*i +: 8] = HWDATA[8*i +: 8];
    end
  end

  // zero-wait read accepted while the previous write commits sees the merged word
  assign fwd_word = (wr_commit && (a_idx == dp_idx)) ? wr_word : mem[a_idx];

  always_ff @(posedge HCLK) begin
    if (wr_commit) mem[dp_idx] <= wr_word;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      cnt      <= 3'd0;
      dp_done  <= 1'b0;
      dp_write <= 1'b0;
      dp_size  <= 3'd0;
      dp_lane  <= 2'b00;
      dp_idx   <= '0;
      HRDATA   <= 32'h0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      dp_done <= dp_done_nxt;
      if (accept) begin
        dp_write <= HWRITE;
        dp_size  <= HSIZE;
        dp_lane  <= HADDR[1:0];
        dp_idx   <= a_idx;
      end
      if (accept && legal && !HWRITE && (WS == 3'd0)) begin
        HRDATA <= fwd_word;
      end else if ((state == ST_WAIT) && (cnt == 3'd1) && !dp_write) begin
        HRDATA <= mem[dp_idx];
      end
    end
  end

endmodule
